uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter among NUM_REQ byte producers using round-robin arbitration.
- Each producer presents bytes over a valid/ready handshake.
- The arbiter latches the winner's byte, pulses the transmitter's start, waits for its done, then re-arbitrates.
- Sits between on-chip producers (debug/status/log sources) and the uart transmit interface (txEnabled/txStart/in/txBusy/txDone).

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - states and constants shared by the UART transmit arbiter (UART_ARB_TAG_EN adds tag framing)
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    TAG       = 2'd3
  } arb_state_t;

  localparam logic [7:0] TAG_PREFIX         = 8'hA0;
  localparam int         DEFAULT_TX_TIMEOUT = 200000;

  // Tag byte identifies the source requester in its low nibble.
  function automatic logic [7:0] make_tag(input logic [3:0] id);
    return TAG_PREFIX | {4'h0, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker: first set request after last_i, wrapping
module uart_tx_arbiter_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_i,
  output logic [ID_W-1:0] winner_o,
  output logic            any_o
);

  always_comb begin
    int              idx;
    logic [ID_W-1:0] sel;
    idx      = 0;
    sel      = '0;
    winner_o = '0;
    // Walk the ring backwards so the nearest requester after last_i is written last.
    for (int k = N; k >= 1; k--) begin
      idx = int'(last_i) + k;
      if (idx >= N) idx = idx - N;
      sel = ID_W'(idx);
      if (req_i[sel]) winner_o = sel;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter among NUM_REQ byte producers
// Optional UART_ARB_TAG_EN: each grant sends a tag byte (TAG_PREFIX | id) before the payload byte.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TX_TIMEOUT,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_enabled,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef UART_ARB_TAG_EN
  localparam arb_state_t ACCEPT_NEXT = TAG;
`else
  localparam arb_state_t ACCEPT_NEXT = LAUNCH;
`endif

  arb_state_t      state_q, state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef UART_ARB_TAG_EN
  logic [7:0]      payload_q, payload_d;
  logic            second_q, second_d;
`endif

  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic [7:0]      pick_byte;
  logic            accept;
  logic            timeout_hit;

  uart_tx_arbiter_rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_i    (req_valid),
    .last_i   (last_q),
    .winner_o (pick_id),
    .any_o    (pick_any)
  );

  // Gated by rst so req_ready reads zero while reset is held.
  assign accept      = (state_q == IDLE) && enable && !tx_busy && pick_any && !rst;
  assign pick_byte   = req_data[{pick_id, 3'b000} +: 8];
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  assign tx_enabled = enable;
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = ACCEPT_NEXT;
      TAG:       state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
`ifdef UART_ARB_TAG_EN
          state_d = second_q ? IDLE : LAUNCH;
`else
          state_d = IDLE;
`endif
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_start    = 1'b0;
    busy        = 1'b1;
    err_timeout = 1'b0;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept) req_ready = NUM_REQ'(1) << pick_id;
      end
      LAUNCH:    tx_start = 1'b1;
      WAIT_DONE: err_timeout = !tx_done && timeout_hit;
      default:   ;
    endcase
  end

  always_comb begin
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
`ifdef UART_ARB_TAG_EN
    payload_d = payload_q;
    second_d  = second_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = pick_id;
`ifdef UART_ARB_TAG_EN
          payload_d = pick_byte;
          second_d  = 1'b0;
`else
          tx_data_d = pick_byte;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG:       tx_data_d = make_tag(4'(grant_q));
`endif
      LAUNCH:    cnt_d = '0;
      WAIT_DONE: begin
        if (tx_done) begin
`ifdef UART_ARB_TAG_EN
          if (!second_q) begin
            tx_data_d = payload_q;
            second_d  = 1'b1;
          end else begin
            last_d = grant_q;
          end
`else
          last_d = grant_q;
`endif
        end else if (timeout_hit) begin
          // Byte is dropped; rotation still advances past this requester.
          last_d = grant_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_q <= '0;
      grant_q   <= '0;
      last_q    <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
`ifdef UART_ARB_TAG_EN
      payload_q <= '0;
      second_q  <= 1'b0;
`endif
    end else begin
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
`ifdef UART_ARB_TAG_EN
      payload_q <= payload_d;
      second_q  <= second_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter with a simple UART model
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_enabled;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  int         model_cnt = 0;
  bit         model_silent = 1'b0;
  logic [7:0] sent_q[$];
  logic [1:0] gid_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_enabled  (tx_enabled),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // UART model: records every started byte, pulses tx_done 20 cycles after tx_start unless silent.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      model_cnt = 0;
      tx_done   = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) tx_done = 1'b1;
      end
      if (tx_start) begin
        sent_q.push_back(tx_data);
        gid_q.push_back(grant_id);
        if (!model_silent) model_cnt = 20;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; req_valid = '0; tx_busy = 1'b0; enable = 1'b1; model_silent = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL wait_idle busy=%b after %0d cycles, want 0", busy, n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; req_valid = 4'hF; req_data = 32'h13121110; tx_busy = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_err_timeout got %b want 0", err_timeout); end
    n_cmp++; if (tx_enabled !== 1'b1) begin n_bad++; $display("FAIL tx_enabled_hi got %b want 1", tx_enabled); end
    enable = 1'b0; #1;
    n_cmp++; if (tx_enabled !== 1'b0) begin n_bad++; $display("FAIL tx_enabled_lo got %b want 0", tx_enabled); end
    enable = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    int n;
    @(posedge clk); #2;
    req_data = 32'h005A0000; req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got %b want 0100", req_ready); end
    @(posedge clk); #2;
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_pulse got %b want 0000", req_ready); end
    n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL single_start got %b want 1", tx_start); end
    n_cmp++; if (tx_data !== 8'h5A) begin n_bad++; $display("FAIL single_data got %h want 5a", tx_data); end
    n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL single_grant got %0d want 2", grant_id); end
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_done && n < 100);
    n_cmp++; if (n != 20) begin n_bad++; $display("FAIL single_done_latency got %0d want 20", n); end
    n_cmp++; if (tx_data !== 8'h5A || busy !== 1'b1) begin n_bad++; $display("FAIL single_hold data=%h busy=%b want 5a/1", tx_data, busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after_done got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int n, viol, base;
    logic [7:0] exp_b;
    do_reset();
    base = sent_q.size();
    req_data = 32'h13121110; req_valid = 4'hF;
    n = 0; viol = 0;
    while (sent_q.size() < base + 5 && n < 400) begin
      @(negedge clk); n++;
      if ($countones(req_ready) > 1 || (req_ready != 4'b0 && busy)) viol++;
    end
    n_cmp++; if (sent_q.size() < base + 5) begin n_bad++; $display("FAIL rr_count got %0d want %0d", sent_q.size() - base, 5); end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rr_ready_onehot violations %0d want 0", viol); end
    for (int k = 0; k < 5; k++) begin
      if (sent_q.size() > base + k) begin
        exp_b = 8'h10 + 8'(k % 4);
        n_cmp++; if (sent_q[base+k] !== exp_b) begin n_bad++; $display("FAIL rr_data[%0d] got %h want %h", k, sent_q[base+k], exp_b); end
        n_cmp++; if (gid_q[base+k] !== 2'(k % 4)) begin n_bad++; $display("FAIL rr_grant[%0d] got %0d want %0d", k, gid_q[base+k], k % 4); end
      end
    end
    @(posedge clk); #2;
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    model_silent = 1'b1;
    req_data = 32'h00008877; req_valid = 4'b0011;
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_start && n < 20);
    n_cmp++; if (tx_start !== 1'b1 || grant_id !== 2'd0) begin n_bad++; $display("FAIL to_start start=%b grant=%0d want 1/0", tx_start, grant_id); end
    n = 0;
    do begin @(negedge clk); n++; end while (!err_timeout && n < 200);
    n_cmp++; if (n != TO) begin n_bad++; $display("FAIL to_latency got %0d want %0d", n, TO); end
    model_silent = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_pulse_width got %b want 0", err_timeout); end
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL to_next_grant got %b want 0010", req_ready); end
    @(posedge clk); #2;
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_busy_enable();
    int bad;
    do_reset();
    req_data = 32'h0000CDAB; tx_busy = 1'b1; req_valid = 4'b0001;
    bad = 0;
    repeat (5) begin @(negedge clk); if (req_ready !== 4'b0000) bad++; end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL busy_block ready cycles %0d want 0", bad); end
    @(posedge clk); #2;
    tx_busy = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL busy_release got %b want 0001", req_ready); end
    @(posedge clk); #2;
    req_valid = '0;
    wait_idle();
    enable = 1'b0; req_valid = 4'b0010;
    bad = 0;
    repeat (5) begin @(negedge clk); if (req_ready !== 4'b0000 || busy !== 1'b0) bad++; end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL enable_block bad cycles %0d want 0", bad); end
    n_cmp++; if (tx_enabled !== 1'b0) begin n_bad++; $display("FAIL enable_tx_enabled got %b want 0", tx_enabled); end
    @(posedge clk); #2;
    enable = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL enable_release got %b want 0010", req_ready); end
    // Dropping enable mid-byte must still let the byte finish.
    @(posedge clk); #2;
    req_valid = '0; enable = 1'b0;
    wait_idle();
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n, starts;
    do_reset();
    req_data = 32'h13121110; req_valid = 4'hF;
    n = 0; starts = 0;
    while (starts < 2 && n < 200) begin @(negedge clk); n++; if (tx_start) starts++; end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || grant_id !== 2'd1 || tx_data !== 8'h11) begin n_bad++; $display("FAIL mid_pre busy=%b grant=%0d data=%h want 1/1/11", busy, grant_id, tx_data); end
    #2; rst = 1'b1; #1;
    n_cmp++; if ({busy, tx_start, err_timeout, req_ready, tx_data, grant_id} !== 16'h0000) begin
      n_bad++; $display("FAIL mid_async_reset busy=%b start=%b err=%b ready=%b data=%h grant=%0d want all 0", busy, tx_start, err_timeout, req_ready, tx_data, grant_id);
    end
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_winner got %b want 0001", req_ready); end
    @(negedge clk);
    n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h10 || grant_id !== 2'd0) begin n_bad++; $display("FAIL mid_restart start=%b data=%h grant=%0d want 1/10/0", tx_start, tx_data, grant_id); end
    @(posedge clk); #2;
    req_valid = '0;
    wait_idle();
  endtask

`ifdef UART_ARB_TAG_EN
  task automatic test_tag();
    int n, base, pulses;
    do_reset();
    base = sent_q.size();
    req_data = 32'hC3000000; req_valid = 4'b1000;
    n = 0; pulses = 0;
    while (sent_q.size() < base + 2 && n < 200) begin
      @(negedge clk); n++;
      if (req_ready !== 4'b0000) pulses++;
    end
    @(posedge clk); #2;
    req_valid = '0;
    n_cmp++; if (sent_q.size() < base + 2) begin n_bad++; $display("FAIL tag_count got %0d want 2", sent_q.size() - base); end
    else begin
      n_cmp++; if (sent_q[base] !== 8'hA3) begin n_bad++; $display("FAIL tag_byte got %h want a3", sent_q[base]); end
      n_cmp++; if (sent_q[base+1] !== 8'hC3) begin n_bad++; $display("FAIL tag_payload got %h want c3", sent_q[base+1]); end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL tag_ready_pulses got %0d want 1", pulses); end
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
`ifdef UART_ARB_TAG_EN
    test_tag();
`else
    test_single();
    test_round_robin();
    test_timeout();
    test_busy_enable();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
